// File: rtl/pio_cfg_sequencer.sv
// pio_cfg_sequencer
// Walks a configuration script held in an external synchronous ROM/RAM and
// replays it onto the pio command port, one single-cycle action per entry.
// PUSH/PULL entries are held off while the addressed FIFO is full/empty,
// with a bounded wait that raises a sticky error.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   start, abort         launch script at address 0 / stop and return to idle
//   busy, done, err      running, end-of-script pulse, wait-timeout flag
//   script_addr          registered script read address
//   script_data          entry {last, action[3:0], mindex[1:0], index[4:0], data[31:0]}
//   pio_action/index/mindex/din   pio command port
//   pio_full, pio_empty  per-machine TX full / RX empty flags
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | script_addr stable, ROM reading
// DECODE | script_data valid; choose DELAY / WAIT / ISSUE / next entry
// WAIT   | PUSH/PULL held off by FIFO flag, timeout running
// ISSUE  | pio_action driven for exactly this cycle
// GAP    | NONE for GAP cycles after an issued action
// DELAY  | NONE for the count carried in a NONE entry
module pio_cfg_sequencer #(
    parameter int ADDR_W  = 6,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] script_addr,
    input  logic [43:0]       script_data,
    output logic [3:0]        pio_action,
    output logic [4:0]        pio_index,
    output logic [1:0]        pio_mindex,
    output logic [31:0]       pio_din,
    input  logic [3:0]        pio_full,
    input  logic [3:0]        pio_empty
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT, S_ISSUE, S_GAP, S_DELAY
    } state_t;

    localparam logic [3:0] A_NONE = 4'd0;
    localparam logic [3:0] A_PULL = 4'd3;
    localparam logic [3:0] A_PUSH = 4'd4;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [15:0]     GAP_LOAD = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        act_q, act_d;
    logic [4:0]        idx_q, idx_d;
    logic [1:0]        mi_q, mi_d;
    logic [31:0]       din_q, din_d;
    // Entry parked in WAIT; the visible command registers only change on
    // entry to ISSUE so they stay stable between issues.
    logic [3:0]        pend_act_q, pend_act_d;
    logic [4:0]        pend_idx_q, pend_idx_d;
    logic [1:0]        pend_mi_q, pend_mi_d;
    logic [31:0]       pend_din_q, pend_din_d;
    logic              last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              err_q, err_d;

    logic              ent_last;
    logic [3:0]        ent_act;
    logic [1:0]        ent_mi;
    logic [4:0]        ent_idx;
    logic [31:0]       ent_data;
    logic              ent_stall;
    logic              pend_stall;
    logic              step;

    assign ent_last = script_data[43];
    assign ent_act  = script_data[42:39];
    assign ent_mi   = script_data[38:37];
    assign ent_idx  = script_data[36:32];
    assign ent_data = script_data[31:0];

    assign ent_stall  = ((ent_act == A_PUSH) && pio_full[ent_mi]) ||
                        ((ent_act == A_PULL) && pio_empty[ent_mi]);
    assign pend_stall = (pend_act_q == A_PUSH) ? pio_full[pend_mi_q] : pio_empty[pend_mi_q];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        act_d      = act_q;
        idx_d      = idx_q;
        mi_d       = mi_q;
        din_d      = din_q;
        pend_act_d = pend_act_q;
        pend_idx_d = pend_idx_q;
        pend_mi_d  = pend_mi_q;
        pend_din_d = pend_din_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        err_d      = err_q;
        done       = 1'b0;
        step       = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        addr_d  = '0;
                        err_d   = 1'b0;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    last_d = ent_last;
                    if (ent_act == A_NONE) begin
                        if (ent_data[15:0] == 16'd0) begin
                            step = 1'b1;
                        end else begin
                            state_d = S_DELAY;
                            cnt_d   = ent_data[15:0] - 16'd1;
                        end
                    end else if (ent_stall) begin
                        state_d    = S_WAIT;
                        wait_d     = '0;
                        pend_act_d = ent_act;
                        pend_idx_d = ent_idx;
                        pend_mi_d  = ent_mi;
                        pend_din_d = ent_data;
                    end else begin
                        state_d = S_ISSUE;
                        act_d   = ent_act;
                        idx_d   = ent_idx;
                        mi_d    = ent_mi;
                        din_d   = ent_data;
                    end
                end
                S_WAIT: begin
                    if (!pend_stall) begin
                        state_d = S_ISSUE;
                        act_d   = pend_act_q;
                        idx_d   = pend_idx_q;
                        mi_d    = pend_mi_q;
                        din_d   = pend_din_q;
                    end else if (wait_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (wait_q != '1) begin
                        wait_d = wait_q + TO_W'(1);
                    end
                end
                S_ISSUE: begin
                    if (GAP == 0) begin
                        step = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
                S_GAP, S_DELAY: begin
                    if (cnt_q == 16'd0) begin
                        step = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Zero-cycle NEXT decision; the top address ends the script
            // rather than wrapping back to 0.
            if (step) begin
                if (last_d || (addr_q == {ADDR_W{1'b1}})) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            act_q      <= '0;
            idx_q      <= '0;
            mi_q       <= '0;
            din_q      <= '0;
            pend_act_q <= '0;
            pend_idx_q <= '0;
            pend_mi_q  <= '0;
            pend_din_q <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            act_q      <= act_d;
            idx_q      <= idx_d;
            mi_q       <= mi_d;
            din_q      <= din_d;
            pend_act_q <= pend_act_d;
            pend_idx_q <= pend_idx_d;
            pend_mi_q  <= pend_mi_d;
            pend_din_q <= pend_din_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;
    assign script_addr = addr_q;
    assign pio_action  = (state_q == S_ISSUE) ? act_q : A_NONE;
    assign pio_index   = idx_q;
    assign pio_mindex  = mi_q;
    assign pio_din     = din_q;

endmodule
